program_loader: RTL and testbench

//  Byte-stream boot loader that drives the CPU's load port: inst/data memory writes taken while the CPU is held in reset.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/byte_assembler.sv | 34 +++
 rtl/program_loader.sv | 201 ++++++++++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_HDR  = 3'd0;
    localparam state_t S_INST = 3'd1;
    localparam state_t S_DATA = 3'd2;
    localparam state_t S_CSUM = 3'd3;
    localparam state_t S_RUN  = 3'd4;
    localparam state_t S_ERR  = 3'd5;

    localparam int HDR_W = 16;
    localparam int LANES = 4;

    function automatic logic takes_bytes(
        input state_t s
    );
        return (s == S_HDR) || (s == S_INST)
            || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects LANES bytes, little-endian, into one word.
// word/word_valid are combinational on the byte that completes the word.
import loader_pkg::*;

module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int SH_W = 8 * (LANES - 1);
    localparam logic [1:0] LAST = 2'(LANES - 1);

    logic [1:0]      lane;
    logic [SH_W-1:0] sh;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= '0;
            sh   <= '0;
        end else if (byte_en) begin
            lane <= lane + 2'd1;
            sh   <= {byte_in, sh[SH_W-1:8]};
        end
    end

    assign word       = {byte_in, sh};
    assign word_valid = byte_en && (lane == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses header/inst/data frames and writes CPU memories.
// Build option: PROGRAM_LOADER_CHECKSUM_EN inserts a CSUM state before RUN.
import loader_pkg::*;

module program_loader #(
    parameter int MAX_INST_WORDS = 1024,
    parameter int MAX_DATA_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        inst_we,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam logic [HDR_W-1:0] MAX_N =
        HDR_W'(MAX_INST_WORDS);
    localparam logic [HDR_W-1:0] MAX_M =
        HDR_W'(MAX_DATA_WORDS);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_RUN;
`endif

    state_t state, state_d;

    logic [HDR_W-1:0] n_words, n_d;
    logic [HDR_W-1:0] m_words, m_d;
    logic [HDR_W-1:0] word_cnt, cnt_d;
    logic             asm_clr;

    logic        accept;
    logic [31:0] word;
    logic        word_valid;

    logic [HDR_W-1:0] hdr_n, hdr_m;
    logic             hdr_bad;

    logic in_ready_d, cpu_rst_d;
    logic done_d, err_d;
    logic inst_we_d, mem_we_d;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign accept  = in_valid && in_ready;
    assign hdr_n   = word[HDR_W-1:0];
    assign hdr_m   = word[2*HDR_W-1:HDR_W];
    assign hdr_bad = (hdr_n > MAX_N)
                  || (hdr_m > MAX_M);

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clr),
        .byte_en    (accept && state != S_CSUM),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HDR;
            n_words   <= '0;
            m_words   <= '0;
            word_cnt  <= '0;
            in_ready  <= 1'b1;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            inst_we   <= 1'b0;
            mem_we    <= 1'b0;
            inst_addr <= '0;
            inst_data <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            state    <= state_d;
            n_words  <= n_d;
            m_words  <= m_d;
            word_cnt <= cnt_d;
            in_ready <= in_ready_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            err      <= err_d;
            inst_we  <= inst_we_d;
            mem_we   <= mem_we_d;
            if (inst_we_d) begin
                inst_addr <= {16'd0, word_cnt};
                inst_data <= word;
            end
            if (mem_we_d) begin
                mem_addr <= {16'd0, word_cnt};
                mem_data <= word;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || asm_clr) begin
            csum <= '0;
        end else if (accept) begin
            if (state == S_INST || state == S_DATA)
                csum <= csum ^ in_data;
        end
    end
`endif

    always_comb begin
        state_d = state;
        n_d     = n_words;
        m_d     = m_words;
        cnt_d   = word_cnt;
        asm_clr = 1'b0;
        unique case (state)
            S_HDR: begin
                if (word_valid) begin
                    n_d   = hdr_n;
                    m_d   = hdr_m;
                    cnt_d = '0;
                    if (hdr_bad)
                        state_d = S_ERR;
                    else if (hdr_n != '0)
                        state_d = S_INST;
                    else if (hdr_m != '0)
                        state_d = S_DATA;
                    else
                        state_d = S_FIN;
                end
            end
            S_INST: begin
                // count == N only when M is 0: drain the last strobe
                if (word_cnt == n_words) begin
                    state_d = S_FIN;
                end else if (word_valid) begin
                    if (word_cnt == n_words - 16'd1
                        && m_words != '0) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = word_cnt + 16'd1;
                    end
                end
            end
            S_DATA: begin
                if (word_cnt == m_words)
                    state_d = S_FIN;
                else if (word_valid)
                    cnt_d = word_cnt + 16'd1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == csum)
                            ? S_RUN : S_ERR;
            end
`endif
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    asm_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_HDR;
                cnt_d   = '0;
                asm_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        in_ready_d = takes_bytes(state_d);
        if (state_d == S_INST && cnt_d == n_d)
            in_ready_d = 1'b0;
        if (state_d == S_DATA && cnt_d == m_d)
            in_ready_d = 1'b0;
        cpu_rst_d = (state_d != S_RUN);
        done_d    = (state_d == S_RUN);
        err_d     = (state_d == S_ERR);
        inst_we_d = (state == S_INST) && word_valid;
        mem_we_d  = (state == S_DATA) && word_valid;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames for program_loader, checked
// against a queue-based frame model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        inst_we;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int vecs = 0;
    int fails = 0;

    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .inst_we   (inst_we),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag,
                       input logic [64:0] obs,
                       input logic [64:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inst_we)
            got_q.push_back({1'b0, inst_addr, inst_data});
        if (mem_we)
            got_q.push_back({1'b1, mem_addr, mem_data});
        if (inst_we || mem_we)
            chk("we_exclusive", 65'(inst_we & mem_we), 65'd0);
    end

    task automatic send_byte(input logic [7:0] b,
                             input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready)
            chk("in_ready_wait", 65'(in_ready), 65'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cmp_strobes(input string tag);
        chk({tag, "_count"}, 65'(got_q.size()),
            65'(exp_q.size()));
        for (int i = 0; i < exp_q.size()
             && i < got_q.size(); i++)
            chk({tag, "_strobe"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Frame model: the loader should write word i of each section
    // at address i, and end in RUN unless the header or checksum is bad.
    task automatic run_frame(input string tag,
                             input int n, input int m,
                             input logic [31:0] w[$],
                             input int gmax,
                             input bit csum_bad,
                             output int lat);
        logic [7:0] bs[$];
        logic [7:0] x;
        bit hdr_bad;
        bit exp_err;
        int t;
        x = 8'h00;
        hdr_bad = (n > 1024) || (m > 1024);
        bs = {n[7:0], n[15:8], m[7:0], m[15:8]};
        exp_err = hdr_bad;
        if (!hdr_bad) begin
            foreach (w[i])
                for (int k = 0; k < 4; k++) begin
                    bs.push_back(w[i][8*k +: 8]);
                    x ^= w[i][8*k +: 8];
                end
            for (int i = 0; i < n; i++)
                exp_q.push_back({1'b0, 32'(i), w[i]});
            for (int j = 0; j < m; j++)
                exp_q.push_back({1'b1, 32'(j), w[n+j]});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            bs.push_back(csum_bad ? ~x : x);
            exp_err = csum_bad;
`endif
        end
        foreach (bs[i])
            send_byte(bs[i], $urandom_range(0, gmax));
        t = 0;
        while (!(done || err) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        lat = t;
        chk({tag, "_done"}, 65'(done), 65'(!exp_err));
        chk({tag, "_err"}, 65'(err), 65'(exp_err));
        chk({tag, "_cpu_rst"}, 65'(cpu_rst), 65'(exp_err));
        chk({tag, "_in_ready"}, 65'(in_ready), 65'd0);
        cmp_strobes(tag);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        chk({tag, "_rl_ready"}, 65'(in_ready), 65'd1);
        chk({tag, "_rl_flags"},
            65'({cpu_rst, done, err}), 65'(3'b100));
    endtask

    initial begin
        logic [31:0] w1[$];
        logic [31:0] none[$];
        logic [31:0] rw[$];
        int lat;
        int n;
        int m;
        int exp_lat1;

        w1 = {32'h20080005, 32'h2009000A, 32'hDEADBEEF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        exp_lat1 = 0;
`else
        exp_lat1 = 1;
`endif

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_flags",
            65'({in_ready, cpu_rst, done, err}),
            65'(4'b1100));
        chk("rst_we", 65'({inst_we, mem_we}), 65'd0);
        chk("rst_inst", {1'b0, inst_addr, inst_data}, 65'd0);
        chk("rst_mem", {1'b0, mem_addr, mem_data}, 65'd0);

        run_frame("t1", 2, 1, w1, 0, 1'b0, lat);
        chk("t1_lat", 65'(lat), 65'(exp_lat1));
        chk("t1_hold_mem", {1'b0, mem_addr, mem_data},
            {1'b0, 32'd0, 32'hDEADBEEF});
        chk("t1_hold_inst", {1'b0, inst_addr, inst_data},
            {1'b0, 32'd1, 32'h2009000A});
        do_reload("t1");

        run_frame("t2", 0, 0, none, 0, 1'b0, lat);
        chk("t2_lat", 65'(lat), 65'd0);
        do_reload("t2");

        run_frame("t3", 2, 1, w1, 5, 1'b0, lat);
        do_reload("t3");

        run_frame("t4", 1025, 0, none, 2, 1'b0, lat);
        chk("t4_lat", 65'(lat), 65'd0);
        do_reload("t4");

        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp_strobes("t5_rst");
        chk("t5_ready", 65'(in_ready), 65'd1);
        run_frame("t5", 2, 1, w1, 0, 1'b0, lat);
        do_reload("t5");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        run_frame("t6_bad", 2, 1, w1, 0, 1'b1, lat);
        do_reload("t6_bad");
        run_frame("t6_good", 2, 1, w1, 0, 1'b0, lat);
        do_reload("t6_good");
`endif

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(0, 5);
            m = $urandom_range(0, 5);
            rw.delete();
            for (int i = 0; i < n + m; i++)
                rw.push_back($urandom);
            run_frame("rnd", n, m, rw, 3, 1'b0, lat);
            do_reload("rnd");
        end

        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(0, 3);
            m = 1025 + $urandom_range(0, 500);
            if (f == 1) begin
                n = m;
                m = 0;
            end
            run_frame("rnd_bad", n, m, none, 2, 1'b0, lat);
            do_reload("rnd_bad");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, fails);
        $finish;
    end

endmodule
